// File: rtl/text_pkg.sv
// Shared constants for the text-entry controller: screen geometry defaults,
// the ASCII codes it treats specially, and the controller state encoding.
package text_pkg;

    localparam int COLS_DEFAULT = 80;
    localparam int ROWS_DEFAULT = 30;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/button_debounce.sv
// Debounces one raw button: two-flop synchroniser, stability counter,
// and a one-cycle pulse when the accepted level rises.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_count;
    logic             r_press;

    // The counter only advances while the synced level disagrees with the
    // accepted level; any agreeing cycle restarts the stability window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_count  <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_count <= '0;
            end else if (r_count == CNT_LAST) begin
                r_stable <= r_sync2;
                r_count  <= '0;
                r_press  <= r_sync2;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/text_entry_controller.sv
// Turns debounced button presses into single-cycle text-buffer writes,
// tracking the cursor and running a full-screen clear sweep.
module text_entry_controller
    import text_pkg::*;
#(
    parameter  int COLS            = COLS_DEFAULT,
    parameter  int ROWS            = ROWS_DEFAULT,
    parameter  int DEBOUNCE_CYCLES = 100000,
    localparam int ADDR_W          = $clog2(COLS * ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        switches,
    input  logic              btn_confirm,
    input  logic              btn_backspace,
    input  logic              btn_clear,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);

    localparam int                N         = COLS * ROWS;
    localparam int                COL_W     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(N - COLS);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

    logic w_pressConfirm;
    logic w_pressBack;
    logic w_pressClear;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbConfirm (
        .clk(clk), .reset(reset), .i_btn(btn_confirm), .o_press(w_pressConfirm)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbBack (
        .clk(clk), .reset(reset), .i_btn(btn_backspace), .o_press(w_pressBack)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbClear (
        .clk(clk), .reset(reset), .i_btn(btn_clear), .o_press(w_pressClear)
    );

    logic [0:0]        r_state;
    logic              r_wrEn;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [7:0]        r_wrData;
    logic [ADDR_W-1:0] r_cursor;
    logic [COL_W-1:0]  r_col;
    logic              r_busy;

    logic              w_doClear;
    logic              w_doBack;
    logic              w_doConfirm;
    logic [ADDR_W-1:0] w_cursorInc;
    logic [ADDR_W-1:0] w_cursorDec;
    logic [ADDR_W-1:0] w_nextRow;
    logic [COL_W-1:0]  w_colInc;
    logic [COL_W-1:0]  w_colDec;

    assign w_doClear   = w_pressClear;
    assign w_doBack    = w_pressBack & ~w_pressClear;
    assign w_doConfirm = w_pressConfirm & ~w_pressBack & ~w_pressClear;

    // The column is tracked alongside the cursor so carriage return never
    // needs a divide by COLS, which matters when COLS is not a power of two.
    assign w_cursorInc = (r_cursor == LAST_ADDR) ? '0 : r_cursor + ADDR_W'(1);
    assign w_cursorDec = r_cursor - ADDR_W'(1);
    assign w_nextRow   = (r_cursor >= LAST_ROW) ? '0
                       : r_cursor + ADDR_W'(COLS) - ADDR_W'(r_col);
    assign w_colInc    = (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
    assign w_colDec    = (r_col == '0) ? COL_LAST : r_col - COL_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_cursor <= '0;
            r_col    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_wrEn <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_doClear) begin
                        r_state  <= ST_CLEAR;
                        r_busy   <= 1'b1;
                        r_wrEn   <= 1'b1;
                        r_wrAddr <= '0;
                        r_wrData <= ASCII_SPACE;
                    end else if (w_doBack) begin
                        if (r_cursor != '0) begin
                            r_cursor <= w_cursorDec;
                            r_col    <= w_colDec;
                            r_wrEn   <= 1'b1;
                            r_wrAddr <= w_cursorDec;
                            r_wrData <= ASCII_SPACE;
                        end
                    end else if (w_doConfirm) begin
                        if (switches == ASCII_CR) begin
                            r_cursor <= w_nextRow;
                            r_col    <= '0;
                        end else begin
                            r_wrEn   <= 1'b1;
                            r_wrAddr <= r_cursor;
                            r_wrData <= switches;
                            r_cursor <= w_cursorInc;
                            r_col    <= w_colInc;
                        end
                    end
                end
                // Presses that land during the sweep are dropped, not queued.
                ST_CLEAR: begin
                    if (r_wrAddr == LAST_ADDR) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_cursor <= '0;
                        r_col    <= '0;
                    end else begin
                        r_wrEn   <= 1'b1;
                        r_wrAddr <= r_wrAddr + ADDR_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en       = r_wrEn;
    assign wr_addr     = r_wrAddr;
    assign wr_data     = r_wrData;
    assign cursor_addr = r_cursor;
    assign busy        = r_busy;

endmodule
